// File: rtl/pipelined_instruction_decode_pkg.sv
// Shared decode definitions: opcode encodings, instruction field positions and
// small per-opcode classification helpers used by the decode stage.
package decode_defs;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b011111;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_B     = 6'b111111;

    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RD_MSB = 20;
    localparam int unsigned RD_LSB = 16;
    localparam int unsigned RT_MSB = 15;
    localparam int unsigned RT_LSB = 11;

    // Every opcode reads rs except the ones that build their result from the immediate alone.
    function automatic logic uses_rs(input logic [5:0] op);
        return !((op == OP_LI) || (op == OP_LUI) || (op == OP_B));
    endfunction

    // Opcodes with a second register source (R-type from rt, branches/stores from rd).
    function automatic logic has_src_b(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_SB) || (op == OP_SW);
    endfunction

    function automatic logic writes_rf(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
               (op == OP_LI) || (op == OP_LUI) || (op == OP_LB) || (op == OP_LW);
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/pipelined_instruction_decode_imm_extend.sv
// Immediate generation: sign-, zero- or upper-extends Instr[15:0] by opcode.
module imm_extend
    import decode_defs::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [5:0]            opcode_i,
    input  logic [15:0]           imm16_i,
    output logic [DATA_WIDTH-1:0] immed_o
);

    logic [31:0] lui32;

    assign lui32 = {imm16_i, 16'h0000};

    // Select extension mode; lui sign-extends its 32-bit result on wide datapaths.
    always_comb begin
        immed_o = '0;
        case (opcode_i)
            OP_BEQ, OP_BNE, OP_LB, OP_SB, OP_LW, OP_SW, OP_ADDI, OP_LI, OP_B:
                immed_o = DATA_WIDTH'($signed(imm16_i));
            OP_LUI:
                immed_o = DATA_WIDTH'($signed(lui32));
            OP_ANDI, OP_ORI:
                immed_o = DATA_WIDTH'(imm16_i);
            default:
                immed_o = '0;
        endcase
    end

endmodule

// File: rtl/pipelined_instruction_decode.sv
// Pipelined instruction decode stage: register file, per-opcode control decode,
// load-use stall and a valid/ready ID/EX output register.
// Optional macro ID_WB_BYPASS_EN forwards writeback data into the operands being
// captured and into operands held in the output register.
module pipelined_instruction_decode
    import decode_defs::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Flush,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [31:0]           Instr,
    input  logic                  WB_WrEn,
    input  logic [4:0]            WB_Addr,
    input  logic [DATA_WIDTH-1:0] WB_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [5:0]            Out_Opcode,
    output logic [4:0]            Out_Rd,
    output logic                  Out_WrEn,
    output logic                  Out_IsLoad,
    output logic [DATA_WIDTH-1:0] Out_Immed,
    output logic [DATA_WIDTH-1:0] Out_RF_A,
    output logic [DATA_WIDTH-1:0] Out_RF_B
);

    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic [5:0]            opcode;
    logic [AW-1:0]         rs_addr, src_b_addr, wb_addr, ld_rd;
    logic                  use_rs, has_b, stall, accept;
    logic [DATA_WIDTH-1:0] rf_a, rf_b, op_a, op_b, immed;

    logic                  out_valid_q, out_wren_q, out_is_load_q;
    logic [5:0]            out_opcode_q;
    logic [4:0]            out_rd_q;
    logic [DATA_WIDTH-1:0] out_immed_q, out_rf_a_q, out_rf_b_q;

    assign opcode     = Instr[31:26];
    assign rs_addr    = Instr[RS_LSB +: AW];
    assign src_b_addr = (opcode == OP_RTYPE) ? Instr[RT_LSB +: AW] : Instr[RD_LSB +: AW];
    assign wb_addr    = WB_Addr[AW-1:0];
    assign use_rs     = uses_rs(opcode);
    assign has_b      = has_src_b(opcode);
    assign ld_rd      = out_rd_q[AW-1:0];

    assign rf_a = regs_q[rs_addr];
    assign rf_b = has_b ? regs_q[src_b_addr] : '0;

`ifdef ID_WB_BYPASS_EN
    logic [AW-1:0] src_a_q, src_b_q;
    logic          src_b_en_q;

    // Forward a same-cycle writeback into the operands being captured (never r0).
    always_comb begin
        op_a = rf_a;
        op_b = rf_b;
        if (WB_WrEn && (wb_addr != '0) && (wb_addr == rs_addr)) op_a = WB_Data;
        if (WB_WrEn && (wb_addr != '0) && has_b && (wb_addr == src_b_addr)) op_b = WB_Data;
    end
`else
    assign op_a = rf_a;
    assign op_b = rf_b;
`endif

    imm_extend #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_imm_extend (
        .opcode_i(opcode),
        .imm16_i (Instr[15:0]),
        .immed_o (immed)
    );

    // Load-use hazard: the instruction in ID/EX is a load whose result this one needs.
    assign stall = In_Valid && out_valid_q && out_is_load_q && (ld_rd != '0) &&
                   ((use_rs && (rs_addr == ld_rd)) || (has_b && (src_b_addr == ld_rd)));

    assign In_Ready = !Flush && !stall && (!out_valid_q || Out_Ready);
    assign accept   = In_Valid && In_Ready;

    // Register file write port; r0 is never written so it always reads zero.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            regs_q <= '{default: '0};
        end else if (WB_WrEn && (wb_addr != '0)) begin
            regs_q[wb_addr] <= WB_Data;
        end
    end

    // ID/EX output register: flush > accept > drain > hold.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_q   <= 1'b0;
            out_opcode_q  <= '0;
            out_rd_q      <= '0;
            out_wren_q    <= 1'b0;
            out_is_load_q <= 1'b0;
            out_immed_q   <= '0;
            out_rf_a_q    <= '0;
            out_rf_b_q    <= '0;
`ifdef ID_WB_BYPASS_EN
            src_a_q       <= '0;
            src_b_q       <= '0;
            src_b_en_q    <= 1'b0;
`endif
        end else if (Flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q   <= 1'b1;
            out_opcode_q  <= opcode;
            out_rd_q      <= Instr[RD_MSB:RD_LSB];
            out_wren_q    <= writes_rf(opcode);
            out_is_load_q <= is_load(opcode);
            out_immed_q   <= immed;
            out_rf_a_q    <= op_a;
            out_rf_b_q    <= op_b;
`ifdef ID_WB_BYPASS_EN
            src_a_q       <= rs_addr;
            src_b_q       <= src_b_addr;
            src_b_en_q    <= has_b;
`endif
        end else if (out_valid_q && Out_Ready) begin
            out_valid_q <= 1'b0;
`ifdef ID_WB_BYPASS_EN
        end else if (out_valid_q) begin
            // Held operands track writebacks to their source registers.
            if (WB_WrEn && (wb_addr != '0) && (wb_addr == src_a_q)) out_rf_a_q <= WB_Data;
            if (WB_WrEn && (wb_addr != '0) && src_b_en_q && (wb_addr == src_b_q)) begin
                out_rf_b_q <= WB_Data;
            end
`endif
        end
    end

    assign Out_Valid  = out_valid_q;
    assign Out_Opcode = out_opcode_q;
    assign Out_Rd     = out_rd_q;
    assign Out_WrEn   = out_wren_q;
    assign Out_IsLoad = out_is_load_q;
    assign Out_Immed  = out_immed_q;
    assign Out_RF_A   = out_rf_a_q;
    assign Out_RF_B   = out_rf_b_q;

endmodule

// File: tb/tb_pipelined_instruction_decode.sv
// Directed self-checking bench for pipelined_instruction_decode (32-bit and 64-bit instances).
module tb_pipelined_instruction_decode;
    import decode_defs::*;

    logic        Clk, Reset_n, Flush, In_Valid, Out_Ready, WB_WrEn;
    logic [31:0] Instr, WB_Data;
    logic [4:0]  WB_Addr;
    logic [63:0] wb_data64;

    logic        In_Ready, Out_Valid, Out_WrEn, Out_IsLoad;
    logic [5:0]  Out_Opcode;
    logic [4:0]  Out_Rd;
    logic [31:0] Out_Immed, Out_RF_A, Out_RF_B;

    logic        in_ready64, out_valid64, out_wren64, out_is_load64;
    logic [5:0]  out_opcode64;
    logic [4:0]  out_rd64;
    logic [63:0] out_immed64, out_rf_a64, out_rf_b64;

    int n_checks = 0;
    int n_fail   = 0;

    assign wb_data64 = {32'h0, WB_Data};

    pipelined_instruction_decode #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Instr(Instr), .WB_WrEn(WB_WrEn), .WB_Addr(WB_Addr), .WB_Data(WB_Data),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Opcode(Out_Opcode), .Out_Rd(Out_Rd),
        .Out_WrEn(Out_WrEn), .Out_IsLoad(Out_IsLoad), .Out_Immed(Out_Immed),
        .Out_RF_A(Out_RF_A), .Out_RF_B(Out_RF_B)
    );

    pipelined_instruction_decode #(.DATA_WIDTH(64), .NUM_REGS(32)) dut64 (
        .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(in_ready64),
        .Instr(Instr), .WB_WrEn(WB_WrEn), .WB_Addr(WB_Addr), .WB_Data(wb_data64),
        .Out_Valid(out_valid64), .Out_Ready(Out_Ready), .Out_Opcode(out_opcode64),
        .Out_Rd(out_rd64), .Out_WrEn(out_wren64), .Out_IsLoad(out_is_load64),
        .Out_Immed(out_immed64), .Out_RF_A(out_rf_a64), .Out_RF_B(out_rf_b64)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rd, input logic [15:0] imm);
        return {op, rs, rd, imm};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        WB_WrEn = 1'b1; WB_Addr = addr; WB_Data = data;
        tick();
        WB_WrEn = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b1; Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1;
        Instr = '0; WB_WrEn = 1'b0; WB_Addr = '0; WB_Data = '0;
        #1 Reset_n = 1'b0;
        tick(); tick();
        n_checks++; if (Out_Valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0h want 0", Out_Valid); end
        n_checks++; if ({Out_Opcode, Out_Rd, Out_WrEn, Out_IsLoad} !== 13'h0) begin n_fail++; $display("FAIL rst_ctrl: got %0h want 0", {Out_Opcode, Out_Rd, Out_WrEn, Out_IsLoad}); end
        n_checks++; if ({Out_Immed, Out_RF_A, Out_RF_B} !== 96'h0) begin n_fail++; $display("FAIL rst_data: got %0h want 0", {Out_Immed, Out_RF_A, Out_RF_B}); end
        Reset_n = 1'b1;
        #1;
        n_checks++; if (In_Ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0h want 1", In_Ready); end
        Flush = 1'b1;
        #1;
        n_checks++; if (In_Ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %0h want 0", In_Ready); end
        Flush = 1'b0;
        tick();
    endtask

    task automatic test_addi();
        Instr = 32'hC003FFFB; In_Valid = 1'b1; Out_Ready = 1'b1;
        #1;
        n_checks++; if (In_Ready !== 1'b1) begin n_fail++; $display("FAIL addi_in_ready: got %0h want 1", In_Ready); end
        tick();
        In_Valid = 1'b0;
        n_checks++; if (Out_Valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0h want 1", Out_Valid); end
        n_checks++; if (Out_Immed !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL addi_immed: got %0h want fffffffb", Out_Immed); end
        n_checks++; if (Out_Rd !== 5'd3) begin n_fail++; $display("FAIL addi_rd: got %0d want 3", Out_Rd); end
        n_checks++; if ({Out_WrEn, Out_IsLoad} !== 2'b10) begin n_fail++; $display("FAIL addi_ctrl: got %b want 10", {Out_WrEn, Out_IsLoad}); end
        n_checks++; if (Out_Opcode !== 6'b110000) begin n_fail++; $display("FAIL addi_opcode: got %b want 110000", Out_Opcode); end
        n_checks++; if (out_immed64 !== 64'hFFFFFFFFFFFFFFFB) begin n_fail++; $display("FAIL addi_immed64: got %0h want fffffffffffffffb", out_immed64); end
        tick();
        n_checks++; if (Out_Valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %0h want 0", Out_Valid); end
    endtask

    task automatic test_load_use();
        Instr = enc(OP_LW, 5'd1, 5'd4, 16'h0010); In_Valid = 1'b1;
        tick();
        n_checks++; if ({Out_IsLoad, Out_WrEn, Out_Rd} !== {2'b11, 5'd4}) begin n_fail++; $display("FAIL lw_ctrl: got %0h want 64", {Out_IsLoad, Out_WrEn, Out_Rd}); end
        n_checks++; if (Out_Immed !== 32'h10) begin n_fail++; $display("FAIL lw_immed: got %0h want 10", Out_Immed); end
        Instr = enc(OP_RTYPE, 5'd4, 5'd6, {5'd5, 11'd0});
        #1;
        n_checks++; if (In_Ready !== 1'b0) begin n_fail++; $display("FAIL lu_stall: got %0h want 0", In_Ready); end
        tick();
        n_checks++; if (Out_Valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got %0h want 0", Out_Valid); end
        n_checks++; if (In_Ready !== 1'b1) begin n_fail++; $display("FAIL lu_release: got %0h want 1", In_Ready); end
        tick();
        In_Valid = 1'b0;
        n_checks++; if ({Out_Valid, Out_Opcode, Out_Rd} !== {1'b1, OP_RTYPE, 5'd6}) begin n_fail++; $display("FAIL lu_issue: got %0h want %0h", {Out_Valid, Out_Opcode, Out_Rd}, {1'b1, OP_RTYPE, 5'd6}); end
        n_checks++; if ({Out_RF_A, Out_RF_B} !== {32'h44, 32'h55}) begin n_fail++; $display("FAIL lu_operands: got %0h want 4400000055", {Out_RF_A, Out_RF_B}); end
        n_checks++; if ({Out_Immed, Out_IsLoad} !== 33'h0) begin n_fail++; $display("FAIL lu_rtype_imm: got %0h want 0", {Out_Immed, Out_IsLoad}); end
        tick();
        // Load followed by instructions that do not depend on it.
        Instr = enc(OP_LW, 5'd1, 5'd4, 16'h0000); In_Valid = 1'b1;
        tick();
        Instr = enc(OP_B, 5'd4, 5'd0, 16'hFFFF);
        #1;
        n_checks++; if (In_Ready !== 1'b1) begin n_fail++; $display("FAIL lu_b_nostall: got %0h want 1", In_Ready); end
        Instr = enc(OP_ADDI, 5'd2, 5'd8, 16'h0001);
        #1;
        n_checks++; if (In_Ready !== 1'b1) begin n_fail++; $display("FAIL lu_indep: got %0h want 1", In_Ready); end
        Instr = enc(OP_SW, 5'd1, 5'd4, 16'h0000);
        #1;
        n_checks++; if (In_Ready !== 1'b0) begin n_fail++; $display("FAIL lu_sw_stall: got %0h want 0", In_Ready); end
        In_Valid = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        Instr = enc(OP_ORI, 5'd5, 5'd9, 16'h8001); In_Valid = 1'b1; Out_Ready = 1'b1;
        tick();
        Out_Ready = 1'b0;
        Instr = enc(OP_ADDI, 5'd0, 5'd10, 16'h0007);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (In_Ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %0h want 0", i, In_Ready); end
            tick();
            n_checks++; if ({Out_Valid, Out_Opcode, Out_Rd, Out_WrEn} !== {1'b1, OP_ORI, 5'd9, 1'b1}) begin n_fail++; $display("FAIL hold_ctrl[%0d]: got %0h want %0h", i, {Out_Valid, Out_Opcode, Out_Rd, Out_WrEn}, {1'b1, OP_ORI, 5'd9, 1'b1}); end
            n_checks++; if ({Out_Immed, Out_RF_A} !== {32'h8001, 32'h55}) begin n_fail++; $display("FAIL hold_data[%0d]: got %0h want 800100000055", i, {Out_Immed, Out_RF_A}); end
        end
        Out_Ready = 1'b1;
        #1;
        n_checks++; if (In_Ready !== 1'b1) begin n_fail++; $display("FAIL hold_resume: got %0h want 1", In_Ready); end
        tick();
        n_checks++; if ({Out_Valid, Out_Rd, Out_Immed} !== {1'b1, 5'd10, 32'h7}) begin n_fail++; $display("FAIL hold_next: got %0h want %0h", {Out_Valid, Out_Rd, Out_Immed}, {1'b1, 5'd10, 32'h7}); end
    endtask

    task automatic test_flush();
        Instr = enc(OP_ANDI, 5'd5, 5'd11, 16'h00F0); In_Valid = 1'b1; Flush = 1'b1;
        #1;
        n_checks++; if (In_Ready !== 1'b0) begin n_fail++; $display("FAIL flush_block: got %0h want 0", In_Ready); end
        tick();
        Flush = 1'b0;
        n_checks++; if (Out_Valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill: got %0h want 0", Out_Valid); end
        #1;
        n_checks++; if (In_Ready !== 1'b1) begin n_fail++; $display("FAIL flush_after: got %0h want 1", In_Ready); end
        tick();
        In_Valid = 1'b0;
        n_checks++; if ({Out_Valid, Out_Rd, Out_Immed, Out_RF_A} !== {1'b1, 5'd11, 32'hF0, 32'h55}) begin n_fail++; $display("FAIL flush_replay: got %0h want %0h", {Out_Valid, Out_Rd, Out_Immed, Out_RF_A}, {1'b1, 5'd11, 32'hF0, 32'h55}); end
        tick();
    endtask

    task automatic test_bypass();
        logic [31:0] exp_a, exp_b;
`ifdef ID_WB_BYPASS_EN
        exp_a = 32'h12345678; exp_b = 32'hBBBB;
`else
        exp_a = 32'h77; exp_b = 32'h44;
`endif
        Instr = enc(OP_RTYPE, 5'd7, 5'd12, 16'h0000); In_Valid = 1'b1;
        WB_WrEn = 1'b1; WB_Addr = 5'd7; WB_Data = 32'h12345678;
        tick();
        WB_WrEn = 1'b0;
        n_checks++; if (Out_RF_A !== exp_a) begin n_fail++; $display("FAIL byp_same_cycle: got %0h want %0h", Out_RF_A, exp_a); end
        n_checks++; if (Out_RF_B !== 32'h0) begin n_fail++; $display("FAIL byp_rt0: got %0h want 0", Out_RF_B); end
        tick();
        n_checks++; if (Out_RF_A !== 32'h12345678) begin n_fail++; $display("FAIL byp_written: got %0h want 12345678", Out_RF_A); end
        Instr = enc(OP_RTYPE, 5'd0, 5'd13, 16'h0000);
        WB_WrEn = 1'b1; WB_Addr = 5'd0; WB_Data = 32'hFFFFFFFF;
        tick();
        WB_WrEn = 1'b0;
        n_checks++; if (Out_RF_A !== 32'h0) begin n_fail++; $display("FAIL byp_r0: got %0h want 0", Out_RF_A); end
        Instr = enc(OP_RTYPE, 5'd5, 5'd14, {5'd4, 11'd0});
        tick();
        In_Valid = 1'b0; Out_Ready = 1'b0;
        WB_WrEn = 1'b1; WB_Addr = 5'd4; WB_Data = 32'hBBBB;
        tick();
        WB_WrEn = 1'b0;
        n_checks++; if ({Out_RF_A, Out_RF_B} !== {32'h55, exp_b}) begin n_fail++; $display("FAIL byp_held: got %0h want %0h", {Out_RF_A, Out_RF_B}, {32'h55, exp_b}); end
        Out_Ready = 1'b1;
        tick();
        n_checks++; if (Out_Valid !== 1'b0) begin n_fail++; $display("FAIL byp_drain: got %0h want 0", Out_Valid); end
    endtask

    task automatic test_imm64();
        Instr = enc(OP_LUI, 5'd0, 5'd1, 16'hABCD); In_Valid = 1'b1;
        tick();
        n_checks++; if (out_immed64 !== 64'hFFFFFFFFABCD0000) begin n_fail++; $display("FAIL lui64: got %0h want ffffffffabcd0000", out_immed64); end
        n_checks++; if ({Out_Immed, Out_WrEn} !== {32'hABCD0000, 1'b1}) begin n_fail++; $display("FAIL lui32: got %0h want %0h", {Out_Immed, Out_WrEn}, {32'hABCD0000, 1'b1}); end
        Instr = enc(OP_ANDI, 5'd0, 5'd2, 16'h8001);
        tick();
        n_checks++; if (out_immed64 !== 64'h0000000000008001) begin n_fail++; $display("FAIL andi64: got %0h want 8001", out_immed64); end
        Instr = enc(OP_B, 5'd0, 5'd0, 16'hFFFF);
        tick();
        In_Valid = 1'b0;
        n_checks++; if (out_immed64 !== 64'hFFFFFFFFFFFFFFFF) begin n_fail++; $display("FAIL b64: got %0h want ffffffffffffffff", out_immed64); end
        n_checks++; if ({out_valid64, out_wren64} !== 2'b10) begin n_fail++; $display("FAIL b64_ctrl: got %b want 10", {out_valid64, out_wren64}); end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        Instr = enc(OP_LW, 5'd5, 5'd6, 16'h0000); In_Valid = 1'b1; Out_Ready = 1'b1;
        tick();
        In_Valid = 1'b0; Out_Ready = 1'b0;
        tick();
        n_checks++; if ({Out_Valid, Out_IsLoad} !== 2'b11) begin n_fail++; $display("FAIL mid_held: got %b want 11", {Out_Valid, Out_IsLoad}); end
        #3 Reset_n = 1'b0;
        #1;
        n_checks++; if ({Out_Valid, Out_IsLoad, Out_Rd, Out_RF_A} !== 39'h0) begin n_fail++; $display("FAIL mid_clear: got %0h want 0", {Out_Valid, Out_IsLoad, Out_Rd, Out_RF_A}); end
        tick();
        Reset_n = 1'b1; Out_Ready = 1'b1;
        Instr = enc(OP_RTYPE, 5'd6, 5'd7, {5'd5, 11'd0}); In_Valid = 1'b1;
        #1;
        n_checks++; if (In_Ready !== 1'b1) begin n_fail++; $display("FAIL mid_no_stall: got %0h want 1", In_Ready); end
        tick();
        In_Valid = 1'b0;
        n_checks++; if ({Out_Valid, Out_RF_B} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL mid_rf_cleared: got %0h want %0h", {Out_Valid, Out_RF_B}, {1'b1, 32'h0}); end
        tick();
    endtask

    initial begin
        test_reset();
        wb_write(5'd4, 32'h44);
        wb_write(5'd5, 32'h55);
        wb_write(5'd7, 32'h77);
        wb_write(5'd0, 32'hDEAD);
        test_addi();
        test_load_use();
        test_hold();
        test_flush();
        test_bypass();
        test_imm64();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
